// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory bus between the fetch stage and instruction memory
interface instr_fetch_if;
    logic [31:0] iaddr;
    logic        cs_n;
    logic [31:0] instrCode;

    modport master (output iaddr, output cs_n, input instrCode);
    modport slave  (input iaddr, input cs_n, output instrCode);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC register, IF/ID pipeline register and fetch FSM; FETCH_MISALIGN_CHECK_EN adds misalign_err
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    instr_fetch_if.master       bus,
    output logic [31:0]         if_id_instr,
    output logic [31:0]         if_id_pc,
    output logic [31:0]         if_id_pc4,
    output logic                if_id_valid,
    output logic [31:0]         fetch_count
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                misalign_err
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc;
    logic        redirect, load_pc, fetch;

    assign bus.iaddr = pc;
    assign bus.cs_n  = state == IDLE;

    // next state and per-cycle actions; a redirect outranks a stall
    always_comb begin
        state_n  = state;
        redirect = state != IDLE && branch_taken;
        fetch    = state == FETCH && !stall && !branch_taken;
`ifdef FETCH_MISALIGN_CHECK_EN
        load_pc  = redirect && branch_target[1:0] == 2'b00;
`else
        load_pc  = redirect;
`endif
        if (state == IDLE)
            state_n = FETCH;
        else
            state_n = (branch_taken || !stall) ? FETCH : HOLD;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // PC, IF/ID register and delivered-instruction counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            fetch_count <= 32'h0;
        end else if (redirect) begin
            pc          <= load_pc ? {branch_target[31:2], 2'b00} : pc;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (fetch) begin
            pc          <= pc + 32'd4;
            if_id_instr <= bus.instrCode;
            if_id_pc    <= pc;
            if_id_pc4   <= pc + 32'd4;
            if_id_valid <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // one-cycle flag for a redirect to a non-word-aligned target
    always_ff @(posedge clk) begin
        if (!rst)
            misalign_err <= 1'b0;
        else
            misalign_err <= redirect && branch_target[1:0] != 2'b00;
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench with a scoreboard of expected IF/ID contents
module tb_instr_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc4, fetch_count;
    logic        if_id_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .bus          (bus),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .fetch_count  (fetch_count)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], 16'hC0DE} ^ 32'h5A5A_0000;
    endfunction

    assign bus.instrCode = mem(bus.iaddr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_iaddr"}, bus.iaddr, 32'h0);
        chk({tag, "_cs_n"}, {31'h0, bus.cs_n}, 32'h1);
        chk({tag, "_instr"}, if_id_instr, NOP);
        chk({tag, "_pc"}, if_id_pc, 32'h0);
        chk({tag, "_pc4"}, if_id_pc4, 32'h0);
        chk({tag, "_valid"}, {31'h0, if_id_valid}, 32'h0);
        chk({tag, "_count"}, fetch_count, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk({tag, "_misalign"}, {31'h0, misalign_err}, 32'h0);
`endif
    endtask

    task automatic fetch_step(input string tag);
        exp_t e;
        sb.push_back('{pc: exp_pc, instr: mem(exp_pc)});
        exp_pc  = exp_pc + 32'd4;
        exp_cnt = exp_cnt + 32'd1;
        step();
        e = sb.pop_front();
        chk({tag, "_if_id_pc"}, if_id_pc, e.pc);
        chk({tag, "_if_id_pc4"}, if_id_pc4, e.pc + 32'd4);
        chk({tag, "_if_id_instr"}, if_id_instr, e.instr);
        chk({tag, "_valid"}, {31'h0, if_id_valid}, 32'h1);
        chk({tag, "_iaddr"}, bus.iaddr, exp_pc);
        chk({tag, "_count"}, fetch_count, exp_cnt);
    endtask

    initial begin
        exp_pc  = 32'h0;
        exp_cnt = 32'h0;
        step();
        chk_reset("rst0");
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h40;
        step();
        chk_reset("rst_override");
        stall = 1'b0;
        rst = 1'b1;
        chk({"idle_cs_n"}, {31'h0, bus.cs_n}, 32'h1);
        step();
        chk("idle_branch_ignored", bus.iaddr, 32'h0);
        chk("fetch_cs_n", {31'h0, bus.cs_n}, 32'h0);
        chk("idle_no_valid", {31'h0, if_id_valid}, 32'h0);
        branch_taken = 1'b0;
        fetch_step("f0");
        fetch_step("f4");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_iaddr", bus.iaddr, 32'h8);
            chk("stall_if_id_pc", if_id_pc, 32'h4);
            chk("stall_count", fetch_count, 32'h2);
            chk("stall_cs_n", {31'h0, bus.cs_n}, 32'h0);
        end
        stall = 1'b0;
        step();
        chk("release_iaddr", bus.iaddr, 32'h8);
        chk("release_count", fetch_count, 32'h2);
        fetch_step("f8");
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h100;
        step();
        chk("br_iaddr", bus.iaddr, 32'h100);
        chk("br_instr", if_id_instr, NOP);
        chk("br_valid", {31'h0, if_id_valid}, 32'h0);
        chk("br_count", fetch_count, exp_cnt);
        stall = 1'b0;
        branch_taken = 1'b0;
        exp_pc = 32'h100;
        fetch_step("f100");
        branch_taken = 1'b1;
        branch_target = 32'h102;
        step();
        branch_taken = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_err", {31'h0, misalign_err}, 32'h1);
        chk("mis_iaddr", bus.iaddr, 32'h104);
`else
        chk("mask_iaddr", bus.iaddr, 32'h100);
        exp_pc = 32'h100;
`endif
        chk("mis_instr", if_id_instr, NOP);
        chk("mis_valid", {31'h0, if_id_valid}, 32'h0);
        fetch_step("after_mis");
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_err_clear", {31'h0, misalign_err}, 32'h0);
`endif
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk("wrap_iaddr", bus.iaddr, 32'hFFFF_FFFC);
        exp_pc = 32'hFFFF_FFFC;
        fetch_step("wrap");
        chk("wrap_pc4_zero", if_id_pc4, 32'h0);
        stall = 1'b1;
        step();
        chk("hold_iaddr", bus.iaddr, 32'h0);
        rst = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h200;
        step();
        chk_reset("rst_hold");
        rst = 1'b1;
        branch_taken = 1'b0;
        stall = 1'b0;
        step();
        chk("post_rst_iaddr", bus.iaddr, 32'h0);
        chk("post_rst_cs_n", {31'h0, bus.cs_n}, 32'h0);
        exp_pc  = 32'h0;
        exp_cnt = 32'h0;
        fetch_step("post_rst_f0");
        chk("sb_empty", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
